sram_banked_port: RTL and testbench

Parametrised request/response port in front of `num_banks` single-port generic SRAM banks. It adds a latency-insensitive valid/ready interface, byte-masked writes, low-order bank interleaving with per-bank chip-select gating, and a 2-entry response buffer so read data survives backpressure. It sits between cache or memory-controller logic and the generic SRAM wrapper, and instantiates one wrapper per bank.

---
 rtl/sram_banked_port_if.sv | 31 +++
 rtl/sram_banked_port.sv | 160 ++++++++++++++++
 tb/tb_sram_banked_port.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sram_banked_port_if.sv
// Request/response bus between a requester (master) and sram_banked_port (slave).
// Address width follows the bank/word geometry of the port it connects to.
interface sram_banked_port_if #(
    parameter int num_bits  = 128,
    parameter int num_words = 256,
    parameter int num_banks = 2
);
    localparam int BW = (num_banks > 1) ? $clog2(num_banks) : 0;
    localparam int AW = $clog2(num_words) + BW;

    logic                  reqvalid;
    logic                  reqready;
    logic                  reqtype;
    logic [AW-1:0]         reqaddr;
    logic [num_bits-1:0]   reqdata;
    logic [num_bits/8-1:0] reqmask;
    logic                  respvalid;
    logic                  respready;
    logic                  resptype;
    logic [num_bits-1:0]   respdata;

    modport master (
        output reqvalid, reqtype, reqaddr, reqdata, reqmask, respready,
        input  reqready, respvalid, resptype, respdata
    );

    modport slave (
        input  reqvalid, reqtype, reqaddr, reqdata, reqmask, respready,
        output reqready, respvalid, resptype, respdata
    );
endinterface

// File: rtl/sram_banked_port.sv
// Banked SRAM port: valid/ready front end, byte-masked writes, low-order bank
// interleave, 2-entry response buffer. Define SRAM_BANKED_PORT_WRITE_RESP_EN for write responses.

module sram_generic_bank #(
    parameter int num_bits  = 128,
    parameter int num_words = 256
) (
    input  logic                         clk,
    input  logic                         csb,
    input  logic                         web,
    input  logic [$clog2(num_words)-1:0] addr,
    input  logic [num_bits-1:0]          d,
    input  logic [num_bits-1:0]          wbm,
    output logic [num_bits-1:0]          q
);
    logic [num_bits-1:0] mem [num_words];

    // Active-low select and write enable; q only moves on a read.
    always_ff @(posedge clk) begin
        if (!csb && !web) begin
            mem[addr] <= (mem[addr] & ~wbm) | (d & wbm);
        end
        if (!csb && web) begin
            q <= mem[addr];
        end
    end
endmodule

module sram_banked_port #(
    parameter int num_bits  = 128,
    parameter int num_words = 256,
    parameter int num_banks = 2
) (
    input logic               clk,
    input logic               reset,
    sram_banked_port_if.slave bus
);
    localparam int BW = (num_banks > 1) ? $clog2(num_banks) : 0;
    localparam int IW = $clog2(num_words);
    localparam int AW = IW + BW;
    localparam int SW = (BW > 0) ? BW : 1;
    localparam int NM = num_bits / 8;
`ifdef SRAM_BANKED_PORT_WRITE_RESP_EN
    localparam bit WR_RESP = 1'b1;
`else
    localparam bit WR_RESP = 1'b0;
`endif

    logic                accept;
    logic [SW-1:0]       req_bank;
    logic [IW-1:0]       req_index;
    logic [num_bits-1:0] req_wbm;
    logic [num_banks-1:0] bank_csb;
    logic [num_bits-1:0] bank_q [num_banks];

    logic                s1_valid;
    logic                s1_type;
    logic [SW-1:0]       s1_bank;
    logic [num_bits-1:0] s1_data;

    logic                fifo_type [2];
    logic [num_bits-1:0] fifo_data [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [2:0]          occ;
    logic                enq;
    logic                deq;

    generate
        if (num_banks > 1) begin : g_bank_sel
            assign req_bank = bus.reqaddr[SW-1:0];
        end else begin : g_single_bank
            assign req_bank = '0;
        end
    endgenerate

    assign req_index = bus.reqaddr[AW-1:BW];
    assign accept    = bus.reqvalid && bus.reqready;

    always_comb begin
        req_wbm = '0;
        for (int k = 0; k < NM; k++) begin
            req_wbm[8*k +: 8] = {8{bus.reqmask[k]}};
        end
    end

    // Only the addressed bank is selected, and only on an accepted request.
    for (genvar b = 0; b < num_banks; b++) begin : g_bank
        assign bank_csb[b] = !(accept && (req_bank == SW'(b)));

        sram_generic_bank #(
            .num_bits  (num_bits),
            .num_words (num_words)
        ) u_bank (
            .clk  (clk),
            .csb  (bank_csb[b]),
            .web  (!bus.reqtype),
            .addr (req_index),
            .d    (bus.reqdata),
            .wbm  (req_wbm),
            .q    (bank_q[b])
        );
    end

    assign s1_data = s1_type ? '0 : bank_q[s1_bank];

    // S1 must park in the FIFO whenever older responses exist or the sink stalls.
    assign enq = s1_valid && ((count != 2'd0) || !bus.respready);
    assign deq = (count != 2'd0) && bus.respready;
    assign occ = {1'b0, count} + {2'b00, s1_valid};

    assign bus.reqready = (occ < 3'd2) && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_type  <= 1'b0;
            s1_bank  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            s1_valid <= accept && (bus.reqtype ? WR_RESP : 1'b1);
            s1_type  <= bus.reqtype;
            s1_bank  <= req_bank;
            if (enq) begin
                wr_ptr <= !wr_ptr;
            end
            if (deq) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_type[wr_ptr] <= s1_type;
            fifo_data[wr_ptr] <= s1_data;
        end
    end

    always_comb begin
        bus.respvalid = 1'b0;
        bus.resptype  = 1'b0;
        bus.respdata  = '0;
        if (count != 2'd0) begin
            bus.respvalid = 1'b1;
            bus.resptype  = fifo_type[rd_ptr];
            bus.respdata  = fifo_data[rd_ptr];
        end else if (s1_valid) begin
            bus.respvalid = 1'b1;
            bus.resptype  = s1_type;
            bus.respdata  = s1_data;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(enq && (count == 2'd2)));
endmodule

// File: tb/tb_sram_banked_port.sv
// Self-checking bench for sram_banked_port: directed vector table, backpressure and
// reset sequences, then random traffic against a queue-based response model.
module tb_sram_banked_port;
    localparam int NB  = 128;
    localparam int NW  = 256;
    localparam int NBK = 2;
    localparam int AW  = 9;
    localparam int NM  = NB / 8;
`ifdef SRAM_BANKED_PORT_WRITE_RESP_EN
    localparam logic WR_RESP = 1'b1;
`else
    localparam logic WR_RESP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sram_banked_port_if #(.num_bits(NB), .num_words(NW), .num_banks(NBK)) bus ();

    sram_banked_port #(.num_bits(NB), .num_words(NW), .num_banks(NBK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          typ;
        logic [NB-1:0] data;
    } resp_t;

    typedef struct {
        logic          v;
        logic          t;
        logic [AW-1:0] a;
        logic [NB-1:0] d;
        logic [NM-1:0] m;
        logic          rr;
        logic          e_ready;
        logic          e_rvalid;
        logic          e_rtype;
        logic [NB-1:0] e_rdata;
    } vec_t;

    logic [NB-1:0] mem_model [1 << AW];
    resp_t         exp_q [$];
    vec_t          tbl [$];
    int            total = 0;
    int            bad = 0;

    task automatic checkOutput(input string name, input logic [NB-1:0] actual, input logic [NB-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One clock cycle: drive at the falling edge, check against the model, then advance the model.
    task automatic applyStimulus(input logic v, input logic t, input logic [AW-1:0] a,
                                 input logic [NB-1:0] d, input logic [NM-1:0] m, input logic rr);
        logic       exp_ready;
        logic [1:0] exp_csb;
        @(negedge clk);
        bus.reqvalid  = v;
        bus.reqtype   = t;
        bus.reqaddr   = a;
        bus.reqdata   = d;
        bus.reqmask   = m;
        bus.respready = rr;
        #1;
        exp_ready = reset && (exp_q.size() < 2);
        checkOutput("reqready", NB'(bus.reqready), NB'(exp_ready));
        checkOutput("respvalid", NB'(bus.respvalid), NB'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            checkOutput("resptype", NB'(bus.resptype), NB'(exp_q[0].typ));
            checkOutput("respdata", bus.respdata, exp_q[0].data);
        end else begin
            checkOutput("idle resptype", NB'(bus.resptype), '0);
            checkOutput("idle respdata", bus.respdata, '0);
        end
        exp_csb = (v && exp_ready) ? ~(2'b01 << a[0]) : 2'b11;
        checkOutput("bank_csb", NB'(dut.bank_csb), NB'(exp_csb));
        if (exp_q.size() != 0 && rr) begin
            void'(exp_q.pop_front());
        end
        if (v && exp_ready) begin
            if (t) begin
                for (int k = 0; k < NM; k++) begin
                    if (m[k]) mem_model[a][8*k +: 8] = d[8*k +: 8];
                end
                if (WR_RESP) exp_q.push_back('{1'b1, '0});
            end else begin
                exp_q.push_back('{1'b0, mem_model[a]});
            end
        end
    endtask

    function automatic vec_t mk(input logic v, input logic t, input logic [AW-1:0] a,
                                input logic [NB-1:0] d, input logic [NM-1:0] m, input logic rr,
                                input logic e_ready, input logic e_rvalid, input logic e_rtype,
                                input logic [NB-1:0] e_rdata);
        vec_t r;
        r.v = v; r.t = t; r.a = a; r.d = d; r.m = m; r.rr = rr;
        r.e_ready = e_ready; r.e_rvalid = e_rvalid; r.e_rtype = e_rtype; r.e_rdata = e_rdata;
        return r;
    endfunction

    initial begin
        logic [NB-1:0] pat_a5;
        logic [NB-1:0] ones;
        logic [NB-1:0] masked;
        logic [NB-1:0] zero;

        pat_a5 = {16{8'hA5}};
        ones   = {NB{1'b1}};
        masked = {{15{8'hFF}}, 8'h00};
        zero   = '0;

        // Write/read, masked write and backpressure sequences with hand-derived outputs.
        tbl.push_back(mk(1, 1, 3, pat_a5, 16'hFFFF, 1,   1, 0,       0,       zero));
        tbl.push_back(mk(1, 0, 3, zero,   16'h0000, 1,   1, WR_RESP, WR_RESP, zero));
        tbl.push_back(mk(0, 0, 0, zero,   16'h0000, 1,   1, 1,       0,       pat_a5));
        tbl.push_back(mk(1, 1, 4, ones,   16'hFFFF, 1,   1, 0,       0,       zero));
        tbl.push_back(mk(1, 1, 4, zero,   16'h0001, 1,   1, WR_RESP, WR_RESP, zero));
        tbl.push_back(mk(1, 0, 4, zero,   16'h0000, 1,   1, WR_RESP, WR_RESP, zero));
        tbl.push_back(mk(0, 0, 0, zero,   16'h0000, 1,   1, 1,       0,       masked));
        tbl.push_back(mk(0, 0, 0, zero,   16'h0000, 1,   1, 0,       0,       zero));
        tbl.push_back(mk(1, 0, 3, zero,   16'h0000, 0,   1, 0,       0,       zero));
        tbl.push_back(mk(1, 0, 4, zero,   16'h0000, 0,   1, 1,       0,       pat_a5));
        tbl.push_back(mk(1, 0, 3, zero,   16'h0000, 0,   0, 1,       0,       pat_a5));
        tbl.push_back(mk(1, 0, 3, zero,   16'h0000, 0,   0, 1,       0,       pat_a5));
        tbl.push_back(mk(0, 0, 0, zero,   16'h0000, 1,   0, 1,       0,       pat_a5));
        tbl.push_back(mk(0, 0, 0, zero,   16'h0000, 1,   1, 1,       0,       masked));
        tbl.push_back(mk(0, 0, 0, zero,   16'h0000, 1,   1, 0,       0,       zero));

        bus.reqvalid  = 1'b0;
        bus.reqtype   = 1'b0;
        bus.reqaddr   = '0;
        bus.reqdata   = '0;
        bus.reqmask   = '0;
        bus.respready = 1'b0;
        #2;
        checkOutput("rst reqready", NB'(bus.reqready), '0);
        checkOutput("rst respvalid", NB'(bus.respvalid), '0);
        checkOutput("rst resptype", NB'(bus.resptype), '0);
        checkOutput("rst respdata", bus.respdata, '0);
        @(negedge clk);
        reset = 1'b1;

        for (int a = 0; a < (1 << AW); a++) begin
            applyStimulus(1, 1, AW'(a), {$urandom, $urandom, $urandom, $urandom}, '1, 1);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, '0, '0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].v, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].rr);
            checkOutput($sformatf("vec%0d reqready", i), NB'(bus.reqready), NB'(tbl[i].e_ready));
            checkOutput($sformatf("vec%0d respvalid", i), NB'(bus.respvalid), NB'(tbl[i].e_rvalid));
            checkOutput($sformatf("vec%0d resptype", i), NB'(bus.resptype), NB'(tbl[i].e_rtype));
            checkOutput($sformatf("vec%0d respdata", i), bus.respdata, tbl[i].e_rdata);
        end

        for (int a = 0; a < 8; a++) applyStimulus(1, 0, AW'(a), '0, '0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, '0, '0, '0, 1);

        // Two responses parked, then reset lands mid-cycle.
        applyStimulus(1, 0, 3, '0, '0, 0);
        applyStimulus(1, 0, 4, '0, '0, 0);
        applyStimulus(0, 0, '0, '0, '0, 0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset respvalid", NB'(bus.respvalid), '0);
        checkOutput("reset reqready", NB'(bus.reqready), '0);
        checkOutput("reset respdata", bus.respdata, '0);
        exp_q.delete();
        applyStimulus(0, 0, '0, '0, '0, 1);
        reset = 1'b1;
        applyStimulus(1, 0, 3, '0, '0, 1);
        applyStimulus(0, 0, '0, '0, '0, 1);
        checkOutput("post-reset read", bus.respdata, pat_a5);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, (1 << AW) - 1)),
                          {$urandom, $urandom, $urandom, $urandom},
                          ($urandom_range(0, 7) == 0) ? '0 : NM'($urandom),
                          $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, '0, '0, '0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
